run_ctrl: RTL and testbench

- Run-control sequencer for the single-cycle MIPS core.
- Consumes per-instruction syscall and branch decode results (halt, pause, display, is-branch, taken) and gates the PC/register-file write enable.
- Latches syscall display values and keeps cycle, branch and taken-branch statistics counters for the board display.
- Sits between the branch/syscall decode logic and the PC register, the display driver and the board buttons.

---
 rtl/run_ctrl.sv | 110 +++++++++++
 tb/tb_run_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/run_ctrl.sv
// run_ctrl: run-control sequencer for the single-cycle MIPS core.
// Gates instruction commit (PC / register file / memory writes) according to
// halt, pause and single-step requests, latches syscall display values and
// keeps cycle / branch / taken-redirect statistics for the board display.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   halt_i, pause_i,    syscall decode of the current instruction
//   disp_i, disp_data_i
//   is_branch_i,        branch/jump decode and redirect of the current instruction
//   taken_i
//   go_i                asynchronous resume button (level, active high)
//   step_i              single-step mode select (quasi-static level)
//   pc_en_o             commit enable, high only in RUN
//   state_o             00 RUN, 01 PAUSE, 10 HALT
//   disp_o, disp_vld_o  latched display value and one-cycle update pulse
//   cycle_cnt_o, branch_cnt_o, taken_cnt_o  wrapping statistics counters
module run_ctrl #(
  parameter int CNT_W  = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt_i,
  input  logic              pause_i,
  input  logic              disp_i,
  input  logic              is_branch_i,
  input  logic              taken_i,
  input  logic [DATA_W-1:0] disp_data_i,
  input  logic              go_i,
  input  logic              step_i,
  output logic              pc_en_o,
  output logic [1:0]        state_o,
  output logic [DATA_W-1:0] disp_o,
  output logic              disp_vld_o,
  output logic [CNT_W-1:0]  cycle_cnt_o,
  output logic [CNT_W-1:0]  branch_cnt_o,
  output logic [CNT_W-1:0]  taken_cnt_o
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    PAUSE = 2'b01,
    HALT  = 2'b10
  } state_t;

  state_t state, state_nxt;
  logic   go_s1, go_s2, go_s3;
  logic   go_pulse;
  logic   commit;

  // Two synchronizer flops, then a third flop for rising-edge detection so a
  // held button produces a single pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      go_s1 <= 1'b0;
      go_s2 <= 1'b0;
      go_s3 <= 1'b0;
    end else begin
      go_s1 <= go_i;
      go_s2 <= go_s1;
      go_s3 <= go_s2;
    end
  end

  assign go_pulse = go_s2 & ~go_s3;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  assign commit  = (state == RUN);
  assign pc_en_o = commit;
  assign state_o = state;

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (halt_i)                 state_nxt = HALT;
        else if (pause_i || step_i) state_nxt = PAUSE;
      end
      PAUSE: begin
        if (go_pulse) state_nxt = RUN;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp_o       <= '0;
      disp_vld_o   <= 1'b0;
      cycle_cnt_o  <= '0;
      branch_cnt_o <= '0;
      taken_cnt_o  <= '0;
    end else begin
      disp_vld_o <= commit & disp_i;
      if (commit) begin
        cycle_cnt_o <= cycle_cnt_o + 1'b1;
        if (is_branch_i) branch_cnt_o <= branch_cnt_o + 1'b1;
        if (taken_i)     taken_cnt_o  <= taken_cnt_o + 1'b1;
        if (disp_i)      disp_o       <= disp_data_i;
      end
    end
  end

endmodule

// File: tb/tb_run_ctrl.sv
module tb_run_ctrl;
  localparam int CNT_W  = 4;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n, halt_i, pause_i, disp_i, is_branch_i, taken_i;
  logic [DATA_W-1:0] disp_data_i;
  logic              go_i, step_i;
  logic              pc_en_o;
  logic [1:0]        state_o;
  logic [DATA_W-1:0] disp_o;
  logic              disp_vld_o;
  logic [CNT_W-1:0]  cycle_cnt_o, branch_cnt_o, taken_cnt_o;

  int checks = 0;
  int errors = 0;

  run_ctrl #(.CNT_W(CNT_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .halt_i(halt_i), .pause_i(pause_i),
    .disp_i(disp_i), .is_branch_i(is_branch_i), .taken_i(taken_i),
    .disp_data_i(disp_data_i), .go_i(go_i), .step_i(step_i),
    .pc_en_o(pc_en_o), .state_o(state_o), .disp_o(disp_o),
    .disp_vld_o(disp_vld_o), .cycle_cnt_o(cycle_cnt_o),
    .branch_cnt_o(branch_cnt_o), .taken_cnt_o(taken_cnt_o)
  );

  always #5 clk = ~clk;

  // Reference model: state as 0 RUN / 1 PAUSE / 2 HALT, counters as integers
  // taken modulo 2^CNT_W, and a history of go_i values seen at past edges.
  int          m_state = 0;
  int          m_cyc = 0, m_br = 0, m_tk = 0;
  logic [31:0] m_disp = '0;
  bit          m_vld = 0;
  bit          go_hist[3] = '{0, 0, 0}; // go at 1, 2, 3 edges ago
  bit          started = 0;
  int          modv = 1 << CNT_W;

  always @(posedge clk) begin
    bit commit, pulse;
    started = 1;
    if (!rst_n) begin
      m_state = 0; m_cyc = 0; m_br = 0; m_tk = 0;
      m_disp = '0; m_vld = 0;
      go_hist = '{0, 0, 0};
    end else begin
      // a pulse fires when go was seen high two edges ago but low three ago
      pulse  = go_hist[1] && !go_hist[2];
      commit = (m_state == 0);
      m_vld  = commit && disp_i;
      if (commit) begin
        m_cyc = (m_cyc + 1) % modv;
        if (is_branch_i) m_br = (m_br + 1) % modv;
        if (taken_i)     m_tk = (m_tk + 1) % modv;
        if (disp_i)      m_disp = disp_data_i;
        if (halt_i)                 m_state = 2;
        else if (pause_i || step_i) m_state = 1;
      end else if (m_state == 1 && pulse) begin
        m_state = 0;
      end
      go_hist[2] = go_hist[1];
      go_hist[1] = go_hist[0];
      go_hist[0] = go_i;
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("state", 64'(state_o), 64'(m_state));
      chk("pc_en", 64'(pc_en_o), 64'(m_state == 0));
      chk("disp", 64'(disp_o), 64'(m_disp));
      chk("disp_vld", 64'(disp_vld_o), 64'(m_vld));
      chk("cycle_cnt", 64'(cycle_cnt_o), 64'(m_cyc));
      chk("branch_cnt", 64'(branch_cnt_o), 64'(m_br));
      chk("taken_cnt", 64'(taken_cnt_o), 64'(m_tk));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic idle_inputs();
    halt_i = 0; pause_i = 0; disp_i = 0; is_branch_i = 0; taken_i = 0;
    disp_data_i = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    cyc(1);
    rst_n = 1;
  endtask

  int base;

  initial begin
    rst_n = 0; go_i = 0; step_i = 0;
    idle_inputs();
    @(negedge clk);
    cyc(2);
    chk("rst_state", 64'(state_o), 64'd0);
    chk("rst_cycle", 64'(cycle_cnt_o), 64'd0);
    chk("rst_disp", 64'(disp_o), 64'd0);
    rst_n = 1;

    // plain commits
    cyc(5);
    chk("lit_cycle5", 64'(cycle_cnt_o), 64'd5);
    chk("lit_pcen_run", 64'(pc_en_o), 64'd1);

    // branch statistics
    is_branch_i = 1; taken_i = 1; cyc(1);
    taken_i = 0; cyc(1);
    taken_i = 1; cyc(1);
    idle_inputs();
    chk("lit_branch3", 64'(branch_cnt_o), 64'd3);
    chk("lit_taken2", 64'(taken_cnt_o), 64'd2);

    // display latch and pulse
    disp_i = 1; disp_data_i = 32'h0000_1234; cyc(1);
    idle_inputs(); disp_data_i = 32'hdead_beef;
    chk("lit_disp", 64'(disp_o), 64'h1234);
    chk("lit_vld_hi", 64'(disp_vld_o), 64'd1);
    cyc(1);
    chk("lit_vld_lo", 64'(disp_vld_o), 64'd0);
    chk("lit_disp_hold", 64'(disp_o), 64'h1234);

    // pause, then a held button resumes exactly once after 3 edges
    pause_i = 1; cyc(1);
    idle_inputs();
    chk("lit_paused", 64'(state_o), 64'd1);
    chk("lit_pcen_pause", 64'(pc_en_o), 64'd0);
    base = int'(cycle_cnt_o);
    cyc(3);
    chk("lit_frozen", 64'(cycle_cnt_o), 64'(base));
    go_i = 1;
    cyc(2);
    chk("lit_go_2edges", 64'(state_o), 64'd1);
    cyc(1);
    chk("lit_go_3edges", 64'(state_o), 64'd0);
    cyc(7);
    go_i = 0;
    chk("lit_one_resume", 64'(state_o), 64'd0);

    // single-step: three pulses give three commits
    step_i = 1; cyc(1);
    chk("lit_step_pause", 64'(state_o), 64'd1);
    base = int'(cycle_cnt_o);
    repeat (3) begin
      go_i = 1; cyc(4);
      go_i = 0; cyc(4);
    end
    chk("lit_step3", 64'(cycle_cnt_o), 64'((base + 3) % modv));
    chk("lit_step_paused", 64'(state_o), 64'd1);
    step_i = 0;
    go_i = 1; cyc(4); go_i = 0; cyc(2);

    // halt with pause: halt wins, go ignored, reset recovers
    halt_i = 1; pause_i = 1; disp_i = 1; disp_data_i = 32'h55; cyc(1);
    idle_inputs();
    chk("lit_halt", 64'(state_o), 64'd2);
    chk("lit_halt_disp", 64'(disp_o), 64'h55);
    go_i = 1; cyc(5); go_i = 0; cyc(5);
    chk("lit_halt_stays", 64'(state_o), 64'd2);
    do_reset();
    chk("lit_rst_run", 64'(state_o), 64'd0);
    chk("lit_rst_cnt", 64'(cycle_cnt_o), 64'd0);

    // counter wrap
    cyc(modv - 1);
    chk("lit_max", 64'(cycle_cnt_o), 64'(modv - 1));
    cyc(1);
    chk("lit_wrap0", 64'(cycle_cnt_o), 64'd0);
    cyc(1);
    chk("lit_wrap1", 64'(cycle_cnt_o), 64'd1);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      halt_i      = ($urandom_range(0, 59) == 0);
      pause_i     = ($urandom_range(0, 14) == 0);
      disp_i      = ($urandom_range(0, 3) == 0);
      is_branch_i = $urandom_range(0, 1);
      taken_i     = $urandom_range(0, 1);
      disp_data_i = $urandom;
      if ($urandom_range(0, 5) == 0)   go_i = ~go_i;
      if ($urandom_range(0, 99) == 0)  step_i = ~step_i;
      rst_n = ($urandom_range(0, 149) != 0);
      cyc(1);
    end
    rst_n = 1;
    idle_inputs();
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
